// File: rtl/imul_stream_ctrl.sv
// imul_stream_ctrl: valid/ready front end for a fixed-latency pipelined multiplier.
// Tracks in-flight tokens and buffers every product so downstream stalls never drop a result.
module imul_stream_ctrl #(
    parameter int W     = 32,
    parameter int LAT   = 4,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic [W-1:0] mul_in0,
    output logic [W-1:0] mul_in1,
    input  logic [W-1:0] mul_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LAT + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(DEPTH + LAT + 1) + 1;

    logic [LAT-1:0] vpipe;
    logic [IW-1:0]  inflight;
    logic [CW-1:0]  count;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [W-1:0]   mem [DEPTH];

    logic [SW-1:0]  credit_sum;
    logic           issue;
    logic           push;
    logic           pop;

    assign mul_in0 = in_a;
    assign mul_in1 = in_b;

    // Every issued token owns a FIFO slot from issue until pop, so the FIFO can never overflow.
    assign credit_sum = SW'(inflight) + SW'(count);
    assign in_ready   = reset && (credit_sum < SW'(DEPTH));

    assign issue     = in_valid && in_ready;
    assign push      = vpipe[LAT-1];
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vpipe    <= '0;
            inflight <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage take its neighbour's pre-edge value,
            // so the loop order does not matter and the chain shifts by exactly one per edge.
            vpipe[0] <= issue;
            for (int i = 1; i < LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
            case ({issue, push})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; count gates out_data, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= mul_out;
        end
    end

endmodule
